// File: rtl/arb_pkg.sv
// arb_pkg: owner-state encoding and grant-select constants for unified_mem_arbiter.
package arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RESP_IF = 2'd1, RESP_LS = 2'd2} owner_e;
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_IF   = 2'd1;
  localparam logic [1:0] SEL_LS   = 2'd2;
endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating counter with increment/clear and a limit-reached flag.
module arb_starve_counter #(
  parameter int LIMIT = 4,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic         at_limit,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    at_limit = cnt_q == W'(LIMIT);
    cnt_d    = clr ? '0 : (inc && !at_limit) ? cnt_q + 1'b1 : cnt_q;
    cnt      = cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between fetch (IF) and load/store (LS) ports.
// Optional ARB_PERF_CNT_EN adds conflict and starvation-override performance counters.
module unified_mem_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_SIZE     = 256,
  parameter int ADDR_BITS    = $clog2(MEM_SIZE),
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_valid,
  output logic                  if_stall,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [DATA_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  ls_valid,
  output logic                  ls_stall,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]           perf_conflict_cnt,
  output logic [31:0]           perf_starve_cnt,
`endif
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  owner_e     owner_q, owner_d;
  logic [1:0] sel;
  logic       gnt_if, gnt_ls, at_limit, override;
  logic [$clog2(STARVE_LIMIT + 1)-1:0] starve_cnt;
  logic       unused_addr_bits;

  arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (if_req & gnt_ls),
    .clr      (gnt_if | ~if_req),
    .at_limit (at_limit),
    .cnt      (starve_cnt)
  );

  // Grants are held off while in reset so stalls simply mirror the requests.
  always_comb begin
    gnt_if    = rst_n & if_req & (~ls_req | at_limit);
    gnt_ls    = rst_n & ls_req & ~gnt_if;
    override  = gnt_if & ls_req & at_limit;
    sel       = gnt_if ? SEL_IF : gnt_ls ? SEL_LS : SEL_NONE;
    owner_d   = owner_e'(sel);
    if_stall  = if_req & ~gnt_if;
    ls_stall  = ls_req & ~gnt_ls;
    mem_en    = gnt_if | gnt_ls;
    mem_we    = gnt_ls & ls_we;
    mem_addr  = gnt_if ? if_addr[ADDR_BITS+1:2] : gnt_ls ? ls_addr[ADDR_BITS+1:2] : '0;
    mem_wdata = gnt_ls ? ls_wdata : '0;
    if_valid  = owner_q == RESP_IF;
    ls_valid  = owner_q == RESP_LS;
    if_rdata  = if_valid ? mem_rdata : '0;
    ls_rdata  = ls_valid ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) owner_q <= IDLE;
    else        owner_q <= owner_d;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_q, conflict_d, starve_q, starve_d;
  always_comb begin
    conflict_d        = conflict_q + {31'd0, if_req & ls_req};
    starve_d          = starve_q + {31'd0, override};
    perf_conflict_cnt = conflict_q;
    perf_starve_cnt   = starve_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      conflict_q <= '0;
      starve_q   <= '0;
    end else begin
      conflict_q <= conflict_d;
      starve_q   <= starve_d;
    end
  assign unused_addr_bits = ^{if_addr[DATA_WIDTH-1:ADDR_BITS+2], if_addr[1:0],
                              ls_addr[DATA_WIDTH-1:ADDR_BITS+2], ls_addr[1:0], starve_cnt};
`else
  assign unused_addr_bits = ^{if_addr[DATA_WIDTH-1:ADDR_BITS+2], if_addr[1:0],
                              ls_addr[DATA_WIDTH-1:ADDR_BITS+2], ls_addr[1:0], starve_cnt, override};
`endif
endmodule
